// File: rtl/fwuart_tx_arb_if.sv
// Byte-stream bundle between N_REQ requesters, the round-robin frame arbiter and fwuart_tx.
// Pure wiring: no latency, no state; the arbiter uses the slave modport, requester/UART side the master.
interface fwuart_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [N_REQ-1:0]   grant;
    logic               busy;

    modport master (
        output req_data,
        output req_valid,
        output req_last,
        output tx_ready,
        input  req_ready,
        input  tx_data,
        input  tx_valid,
        input  grant,
        input  busy
    );

    modport slave (
        input  req_data,
        input  req_valid,
        input  req_last,
        input  tx_ready,
        output req_ready,
        output tx_data,
        output tx_valid,
        output grant,
        output busy
    );
endinterface

// File: rtl/fwuart_tx_arb.sv
// Frame-locked round-robin arbiter sharing one fwuart_tx byte port; 1-cycle grant latency, bytes pass through combinationally.
// Backpressure: tx_ready is forwarded only to the owner's req_ready; others wait; GAP_CYCLES idle cycles follow each frame.
module fwuart_tx_arb #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 16
) (
    input logic            clock,
    input logic            reset_n,
    fwuart_tx_arb_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [N_REQ-1:0] win_oh;
    logic [PTR_W-1:0] next_ptr;
    logic [7:0]       tx_data_o;
    logic             tx_valid_o;
    logic [N_REQ-1:0] req_ready_o;
    logic             last_hs;

    // First requesting index at or after the rr pointer, wrapping.
    always_comb begin : arb_pick
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        win_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_q) + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                win_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        next_ptr = rr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                next_ptr = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    always_comb begin
        tx_data_o   = '0;
        tx_valid_o  = 1'b0;
        req_ready_o = '0;
        if (state_q == ST_XFER) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_q[i]) begin
                    tx_data_o  = bus.req_data[8*i +: 8];
                    tx_valid_o = bus.req_valid[i];
                end
            end
            req_ready_o = grant_q & {N_REQ{bus.tx_ready}};
        end
    end

    // req_last only counts on the owner's lane and only while its byte is actually taken.
    assign last_hs = (state_q == ST_XFER) && tx_valid_o && bus.tx_ready && |(grant_q & bus.req_last);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = win_oh;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (last_hs) begin
                    grant_d = '0;
                    rr_d    = next_ptr;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_INIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.tx_data   = tx_data_o;
    assign bus.tx_valid  = tx_valid_o;
    assign bus.req_ready = req_ready_o;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fwuart_tx_arb.sv
// Scoreboarded bench for fwuart_tx_arb: directed frames then randomized traffic against a frame-level model.
module tb_fwuart_tx_arb;
    localparam int N   = 4;
    localparam int GAP = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fwuart_tx_arb_if #(.N_REQ(N)) bus ();

    fwuart_tx_arb #(.N_REQ(N), .GAP_CYCLES(GAP)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] drv_q [N][$];
    logic [8:0] exp_q [N][$];
    int         exp_owner_q[$];
    int         pause_cnt  [N];
    int         frames_left[N];
    bit         rand_mode = 1'b0;
    logic       txr       = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic enq_byte(input int i, input logic [7:0] b, input logic last);
        drv_q[i].push_back({last, b});
        exp_q[i].push_back({last, b});
    endtask

    task automatic enq_rand(input int i, input int n);
        for (int k = 0; k < n; k++) enq_byte(i, 8'($urandom), k == n - 1);
    endtask

    // Requester lanes: head byte is held until accepted; idle lanes carry noise on data/last.
    task automatic drive();
        logic [8*N-1:0] d;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        d = '0;
        v = '0;
        l = '0;
        for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() > 0) begin
                d[8*i +: 8] = drv_q[i][0][7:0];
                v[i]        = (pause_cnt[i] == 0);
                l[i]        = (pause_cnt[i] == 0) ? drv_q[i][0][8] : 1'($urandom);
            end else begin
                d[8*i +: 8] = 8'($urandom);
                l[i]        = 1'($urandom);
            end
            if (pause_cnt[i] > 0) pause_cnt[i]--;
        end
        bus.req_data  = d;
        bus.req_valid = v;
        bus.req_last  = l;
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clock);
        acc = bus.req_valid & bus.req_ready & {N{reset_n}};
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (drv_q[i].size() == 0 && frames_left[i] > 0 && $urandom_range(0, 5) == 0) begin
                    enq_rand(i, $urandom_range(1, 5));
                    frames_left[i]--;
                end else if (drv_q[i].size() > 0 && pause_cnt[i] == 0 && $urandom_range(0, 19) == 0) begin
                    pause_cnt[i] = $urandom_range(1, 4);
                end
            end
            bus.tx_ready = ($urandom_range(0, 3) != 0);
        end else begin
            bus.tx_ready = txr;
        end
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = bus.busy;
        for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pending() && n < 3000) begin
            step();
            n++;
        end
        check({"drain_timeout_", tag}, 64'(n >= 3000), 64'd0);
    endtask

    // Monitor: frame-level model of ownership, rr order and gap timing.
    initial begin : monitor
        logic [N-1:0] g;
        logic [N-1:0] pg;
        logic [N-1:0] prv;
        logic         rst_prev;
        logic [8:0]   e;
        int           cyc;
        int           last_cyc;
        int           rr;
        int           ow;
        bit           in_gap;
        pg       = '0;
        prv      = '0;
        rst_prev = 1'b0;
        cyc      = 0;
        last_cyc = -1000;
        rr       = 0;
        forever begin
            @(negedge clock);
            cyc++;
            g  = bus.grant;
            ow = -1;
            for (int i = 0; i < N; i++) if (g[i]) ow = i;
            if (!rst_prev) begin
                check("reset_outputs", {g, bus.req_ready, bus.tx_valid, bus.tx_data, bus.busy}, 64'd0);
                rr       = 0;
                last_cyc = -1000;
            end else begin
                check("grant_onehot0", 64'($onehot0(g)), 64'd1);
                if (ow >= 0) begin
                    check("tx_valid", bus.tx_valid, bus.req_valid[ow]);
                    check("tx_data", bus.tx_data, bus.req_data[8*ow +: 8]);
                end else begin
                    check("idle_tx", {bus.tx_valid, bus.tx_data}, 64'd0);
                end
                check("req_ready", bus.req_ready, g & {N{bus.tx_ready}});
                in_gap = (cyc > last_cyc) && (cyc <= last_cyc + GAP);
                check("busy", bus.busy, 64'((g != 0) || in_gap));
                if (cyc > last_cyc && cyc <= last_cyc + GAP + 1) check("gap_no_grant", g, 64'd0);
                if (pg != 0 && last_cyc != cyc - 1) check("grant_hold", g, pg);
                if (pg == 0 && prv == 0) check("no_spurious_grant", g, 64'd0);
                if (pg == 0 && prv != 0 && cyc - 1 > last_cyc + GAP) begin
                    check("arb_winner", g, N'(1) << winner(prv, rr));
                    if (g != 0 && exp_owner_q.size() > 0) check("owner_order", 64'(ow), 64'(exp_owner_q.pop_front()));
                end
                if (reset_n && bus.tx_valid && bus.tx_ready && ow >= 0) begin
                    if (exp_q[ow].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_byte: requester %0d delivered %0h, none expected", ow, bus.tx_data);
                    end else begin
                        e = exp_q[ow].pop_front();
                        check("byte", {bus.req_last[ow], bus.tx_data}, e);
                        if (e[8]) begin
                            rr       = (ow + 1) % N;
                            last_cyc = cyc;
                        end
                    end
                end
            end
            pg       = g;
            prv      = bus.req_valid;
            rst_prev = reset_n;
        end
    end

    initial begin : stimulus
        int n;
        for (int i = 0; i < N; i++) begin
            pause_cnt[i]   = 0;
            frames_left[i] = 0;
        end
        bus.tx_ready = 1'b1;
        drive();

        // Contention from reset: req1 then req2, leaving rr at 3.
        enq_rand(1, 3);
        enq_rand(2, 2);
        exp_owner_q.push_back(1);
        exp_owner_q.push_back(2);
        repeat (3) step();
        reset_n = 1'b1;
        drain("contention");

        enq_rand(0, 2);
        enq_rand(3, 2);
        exp_owner_q.push_back(3);
        exp_owner_q.push_back(0);
        drain("rr3");

        // Wrap: after req3, req0 beats req3.
        enq_rand(3, 3);
        exp_owner_q.push_back(3);
        drain("req3_alone");
        enq_rand(0, 2);
        enq_rand(3, 2);
        exp_owner_q.push_back(0);
        exp_owner_q.push_back(3);
        drain("wrap");

        enq_byte(0, 8'h55, 1'b0);
        enq_byte(0, 8'hAA, 1'b0);
        enq_byte(0, 8'h0F, 1'b1);
        exp_owner_q.push_back(0);
        drain("single");

        // Ten-cycle tx_ready stall after the first byte.
        enq_rand(1, 4);
        exp_owner_q.push_back(1);
        n = 0;
        while (exp_q[1].size() != 3 && n < 200) begin
            step();
            n++;
        end
        check("stall_reached", 64'(n < 200), 64'd1);
        txr          = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (9) step();
        check("stall_bytes_held", 64'(exp_q[1].size()), 64'd3);
        txr = 1'b1;
        drain("stall");

        // Owner drops valid for 5 cycles while req2 waits.
        enq_rand(0, 4);
        exp_owner_q.push_back(0);
        exp_owner_q.push_back(2);
        n = 0;
        while (exp_q[0].size() != 2 && n < 200) begin
            step();
            n++;
        end
        check("owner_gap_reached", 64'(n < 200), 64'd1);
        enq_rand(2, 3);
        pause_cnt[0] = 5;
        drive();
        repeat (4) step();
        check("owner_gap_held", 64'(exp_q[0].size()), 64'd2);
        drain("owner_gap");

        // Reset after the 2nd of 4 bytes; req0 wins first afterwards.
        enq_rand(1, 4);
        exp_owner_q.push_back(1);
        n = 0;
        while (exp_q[1].size() != 2 && n < 200) begin
            step();
            n++;
        end
        check("reset_point_reached", 64'(n < 200), 64'd1);
        reset_n = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            pause_cnt[i] = 0;
        end
        step();
        enq_rand(3, 2);
        enq_rand(0, 2);
        exp_owner_q.push_back(0);
        exp_owner_q.push_back(3);
        reset_n = 1'b1;
        drain("after_reset");
        check("owner_log_consumed", 64'(exp_owner_q.size()), 64'd0);

        // Randomized traffic, stalls and owner pauses.
        for (int i = 0; i < N; i++) frames_left[i] = 10;
        rand_mode = 1'b1;
        n = 0;
        while (n < 20000) begin
            bit done;
            done = !pending();
            for (int i = 0; i < N; i++) if (frames_left[i] > 0) done = 1'b0;
            if (done) break;
            step();
            n++;
        end
        rand_mode = 1'b0;
        check("random_timeout", 64'(n >= 20000), 64'd0);
        for (int i = 0; i < N; i++) check("scoreboard_empty", 64'(exp_q[i].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
